// File: rtl/adder_arb_pkg.sv
// Shared definitions for the two-requester adder arbiter: FSM state
// encoding, operand width default, requester ids and the arbitration rule.
package adder_arb_pkg;

    localparam int DEF_DATA_W = 17;
    localparam int DEF_SUM_W  = DEF_DATA_W + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ADD    = 2'd1,
        S_RESULT = 2'd2
    } arb_state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // A lone requester always wins; on a tie the one not served last wins.
    function automatic logic pick_winner(input logic r0, input logic r1, input logic last_gnt);
        if (r0 && r1) begin
            return ~last_gnt;
        end else if (r1) begin
            return REQ1;
        end else begin
            return REQ0;
        end
    endfunction

endpackage

// File: rtl/adder_one.sv
// Combinational 17-bit ripple-carry adder; sum[17] is the carry out.
module adder_one
    import adder_arb_pkg::*;
(
    input  logic [DEF_DATA_W-1:0] a,
    input  logic [DEF_DATA_W-1:0] b,
    output logic [DEF_SUM_W-1:0]  sum
);

    // Ripple the carry bit by bit through a chain of full adders.
    always_comb begin
        logic c;
        sum = '0;
        c   = 1'b0;
        for (int i = 0; i < DEF_DATA_W; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        sum[DEF_SUM_W-1] = c;
    end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one adder_one between two requesters.
// Operands are registered on grant, summed in ADD, and the 18-bit result
// is held in RESULT until the consumer accepts it.
// Optional feature: define ADDER_ARB_STATS_EN to add saturating per-requester
// grant counters (gnt_cnt0/gnt_cnt1).
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   S_IDLE   | waiting for a request; grants and acks the winner
//   S_ADD    | adder fed from operand regs, sum captured on the edge
//   S_RESULT | res_valid high, held until res_ready
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int DATA_W = 17,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] b0,
    output logic              ack0,
    input  logic              req1,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] b1,
    output logic              ack1,
    output logic [DATA_W:0]   res,
    output logic              res_id,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              busy
`ifdef ADDER_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  gnt_cnt0,
    output logic [CNT_W-1:0]  gnt_cnt1
`endif
);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W:0]   sum;
    logic              last_gnt;
    logic              winner;
    logic              grant;

    // Arbitration decision from the live requests and the last winner.
    always_comb begin
        winner = pick_winner(req0, req1, last_gnt);
    end

    // Next state and grant pulses; acks only ever come out of IDLE.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        ack0      = 1'b0;
        ack1      = 1'b0;
        case (state)
            S_IDLE: begin
                if (req0 || req1) begin
                    grant     = 1'b1;
                    state_nxt = S_ADD;
                    ack0      = (winner == REQ0);
                    ack1      = (winner == REQ1);
                end
            end
            S_ADD: begin
                state_nxt = S_RESULT;
            end
            S_RESULT: begin
                if (res_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        // Keep acks at their reset value while reset is held.
        if (reset) begin
            ack0 = 1'b0;
            ack1 = 1'b0;
        end
    end

    assign res_valid = (state == S_RESULT);
    assign busy      = (state != S_IDLE);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture the winner's operands, its id and the round-robin pointer on grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_a     <= '0;
            op_b     <= '0;
            res_id   <= REQ0;
            last_gnt <= REQ1;
        end else if (grant) begin
            op_a     <= (winner == REQ1) ? a1 : a0;
            op_b     <= (winner == REQ1) ? b1 : b0;
            res_id   <= winner;
            last_gnt <= winner;
        end
    end

    adder_one u_adder_one (
        .a   (op_a),
        .b   (op_b),
        .sum (sum)
    );

    // Register the sum at the end of ADD; it stays put through RESULT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res <= '0;
        end else if (state == S_ADD) begin
            res <= sum;
        end
    end

`ifdef ADDER_ARB_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Saturating grant counters, one per requester.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else begin
            if (ack0 && gnt_cnt0 != CNT_MAX) begin
                gnt_cnt0 <= gnt_cnt0 + 1'b1;
            end
            if (ack1 && gnt_cnt1 != CNT_MAX) begin
                gnt_cnt1 <= gnt_cnt1 + 1'b1;
            end
        end
    end
`else
    // Counter width only matters when statistics are built in.
    if (CNT_W > 0) begin : g_no_stats
    end
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: directed scenarios followed by a
// randomized run, all compared against a transaction-level reference model.
// Builds with or without ADDER_ARB_STATS_EN.
module tb_adder_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [16:0] a0, b0, a1, b1;
    logic        res_ready;
    logic        ack0, ack1;
    logic [17:0] res;
    logic        res_id, res_valid, busy;
`ifdef ADDER_ARB_STATS_EN
    logic [15:0] gnt_cnt0, gnt_cnt1;
    logic [1:0]  s_cnt0, s_cnt1;
    logic        s_ack0, s_ack1, s_res_id, s_res_valid, s_busy;
    logic [17:0] s_res;
`endif

    always #5 clk = ~clk;

    adder_arbiter #(.DATA_W(17), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset),
        .req0(req0), .a0(a0), .b0(b0), .ack0(ack0),
        .req1(req1), .a1(a1), .b1(b1), .ack1(ack1),
        .res(res), .res_id(res_id), .res_valid(res_valid),
        .res_ready(res_ready), .busy(busy)
`ifdef ADDER_ARB_STATS_EN
        , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
    );

`ifdef ADDER_ARB_STATS_EN
    adder_arbiter #(.DATA_W(17), .CNT_W(2)) u_dut_sat (
        .clk(clk), .reset(reset),
        .req0(req0), .a0(a0), .b0(b0), .ack0(s_ack0),
        .req1(req1), .a1(a1), .b1(b1), .ack1(s_ack1),
        .res(s_res), .res_id(s_res_id), .res_valid(s_res_valid),
        .res_ready(res_ready), .busy(s_busy),
        .gnt_cnt0(s_cnt0), .gnt_cnt1(s_cnt1)
    );
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: one outstanding transaction, identified by how many
    // edges have passed since its grant.
    bit          m_pending;
    int          m_age;
    bit          m_last;
    logic [17:0] m_res;
    bit          m_id;
    int          m_gc0, m_gc1;
    bit          g_ack0, g_ack1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_pending = 1'b0;
        m_age     = 0;
        m_last    = 1'b1;
        m_res     = '0;
        m_id      = 1'b0;
        m_gc0     = 0;
        m_gc1     = 0;
        g_ack0    = 1'b0;
        g_ack1    = 1'b0;
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic cycle();
        bit e_ack0, e_ack1, e_valid, w;
        #1;
        e_valid = m_pending && (m_age >= 1);
        e_ack0  = 1'b0;
        e_ack1  = 1'b0;
        w       = 1'b0;
        if (!m_pending && (req0 || req1)) begin
            w      = (req0 && req1) ? !m_last : req1;
            e_ack0 = !w;
            e_ack1 = w;
        end
        check_val("ack0", ack0, e_ack0);
        check_val("ack1", ack1, e_ack1);
        check_val("res_valid", res_valid, e_valid);
        check_val("busy", busy, m_pending);
        if (e_valid) begin
            check_val("res", res, m_res);
            check_val("res_id", res_id, m_id);
        end
        @(posedge clk);
        if (e_ack0 || e_ack1) begin
            m_pending = 1'b1;
            m_age     = 0;
            m_last    = w;
            m_id      = w;
            m_res     = w ? ({1'b0, a1} + {1'b0, b1}) : ({1'b0, a0} + {1'b0, b0});
            if (w) m_gc1++; else m_gc0++;
        end else if (m_pending) begin
            if (e_valid && res_ready) m_pending = 1'b0;
            else m_age++;
        end
        g_ack0 = e_ack0;
        g_ack1 = e_ack1;
        cyc++;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_res"}, res, 18'd0);
        check_val({tag, "_valid"}, res_valid, 1'b0);
        check_val({tag, "_busy"}, busy, 1'b0);
        check_val({tag, "_id"}, res_id, 1'b0);
        check_val({tag, "_acks"}, {ack1, ack0}, 2'b00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #2;
        check_reset_outputs("rst");
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // Single grant to one requester with an immediately ready consumer.
    task automatic do_grant(input bit id, input logic [16:0] a, input logic [16:0] b);
        res_ready = 1'b1;
        if (id) begin req1 = 1'b1; a1 = a; b1 = b; end
        else    begin req0 = 1'b1; a0 = a; b0 = b; end
        cycle();
        req0 = 1'b0;
        req1 = 1'b0;
        cycle();
        cycle();
    endtask

    function automatic logic [16:0] rand_op();
        case ($urandom_range(3, 0))
            0:       return 17'h00000;
            1:       return 17'h1FFFF;
            default: return 17'($urandom);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; req0 = 0; req1 = 0; res_ready = 0;
        a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        model_reset();
        #3;
        check_reset_outputs("por");
        do_reset();

        // 1: single request, latency and release.
        req0 = 1'b1; a0 = 17'd5; b0 = 17'd7; res_ready = 1'b1;
        cycle();
        req0 = 1'b0;
        cycle();
        #1;
        check_val("t1_valid", res_valid, 1'b1);
        check_val("t1_res", res, 18'd12);
        check_val("t1_id", res_id, 1'b0);
        cycle();
        #1;
        check_val("t1_idle", busy, 1'b0);
        cycle();

        // 2: both requesting from reset; grants alternate starting with req0.
        do_reset();
        req0 = 1'b1; req1 = 1'b1;
        a0 = 17'd3; b0 = 17'd4; a1 = 17'h10; b1 = 17'd1;
        res_ready = 1'b1;
        for (int g = 0; g < 4; g++) begin
            #1;
            check_val("t2_gnt", {ack1, ack0}, (g % 2) ? 2'b10 : 2'b01);
            cycle();
            cycle();
            #1;
            check_val("t2_res", res, (g % 2) ? 18'h11 : 18'd7);
            check_val("t2_id", res_id, g % 2);
            cycle();
        end
        req0 = 1'b0; req1 = 1'b0;

        // 3: extremes of the operand range.
        do_grant(1'b0, 17'h1FFFF, 17'h1FFFF);
        check_val("t3_max", res, 18'h3FFFE);
        do_grant(1'b0, 17'h0, 17'h0);
        check_val("t3_zero", res, 18'h0);

        // 4: backpressure with a waiting requester.
        req0 = 1'b1; a0 = 17'd100; b0 = 17'd200; res_ready = 1'b0;
        cycle();
        req0 = 1'b0;
        req1 = 1'b1; a1 = 17'd7; b1 = 17'd9;
        cycle();
        for (int i = 0; i < 10; i++) begin
            #1;
            check_val("t4_valid", res_valid, 1'b1);
            check_val("t4_res", res, 18'd300);
            check_val("t4_noack", ack1, 1'b0);
            cycle();
        end
        res_ready = 1'b1;
        cycle();
        #1;
        check_val("t4_ack1", ack1, 1'b1);
        cycle();
        req1 = 1'b0;
        cycle();
        cycle();

        // 5: reset in ADD, then in RESULT.
        req0 = 1'b1; a0 = 17'd1; b0 = 17'd2; res_ready = 1'b1;
        cycle();
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("t5_add");
        req0 = 1'b1; req1 = 1'b1; a1 = 17'd40; b1 = 17'd2;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        check_val("t5_first", {ack1, ack0}, 2'b01);
        cycle();
        req0 = 1'b0; req1 = 1'b0; res_ready = 1'b0;
        cycle();
        #1;
        check_val("t5_inres", res_valid, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        check_reset_outputs("t5_res");
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        res_ready = 1'b1;
        cycle();
        cycle();

`ifdef ADDER_ARB_STATS_EN
        // 6: counters and saturation.
        do_reset();
        for (int i = 0; i < 5; i++) do_grant(1'b0, 17'(i), 17'd1);
        for (int i = 0; i < 3; i++) do_grant(1'b1, 17'(i), 17'd2);
        #1;
        check_val("t6_cnt0", gnt_cnt0, 16'd5);
        check_val("t6_cnt1", gnt_cnt1, 16'd3);
        check_val("t6_sat0", s_cnt0, 2'd3);
        check_val("t6_sat1", s_cnt1, 2'd3);
        do_reset();
`endif

        // Randomized traffic with withdrawals and random backpressure.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cycle();
            if (req0) begin
                if (g_ack0) begin
                    if ($urandom_range(1, 0) == 0) req0 = 1'b0;
                    else begin a0 = rand_op(); b0 = rand_op(); end
                end else if ($urandom_range(7, 0) == 0) begin
                    req0 = 1'b0;
                end
            end else if ($urandom_range(2, 0) == 0) begin
                req0 = 1'b1; a0 = rand_op(); b0 = rand_op();
            end
            if (req1) begin
                if (g_ack1) begin
                    if ($urandom_range(1, 0) == 0) req1 = 1'b0;
                    else begin a1 = rand_op(); b1 = rand_op(); end
                end else if ($urandom_range(7, 0) == 0) begin
                    req1 = 1'b0;
                end
            end else if ($urandom_range(2, 0) == 0) begin
                req1 = 1'b1; a1 = rand_op(); b1 = rand_op();
            end
            res_ready = ($urandom_range(3, 0) != 0);
        end
`ifdef ADDER_ARB_STATS_EN
        #1;
        check_val("rnd_cnt0", gnt_cnt0, (m_gc0 > 65535) ? 65535 : m_gc0);
        check_val("rnd_cnt1", gnt_cnt1, (m_gc1 > 65535) ? 65535 : m_gc1);
        check_val("rnd_sat0", s_cnt0, (m_gc0 > 3) ? 3 : m_gc0);
        check_val("rnd_sat1", s_cnt1, (m_gc1 > 3) ? 3 : m_gc1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
